regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file and shares it between two writeback requesters.
  - Requester A: the single-cycle ALU/load writeback path.
  - Requester B: a multi-cycle unit (MDU, slow load).
- Keeps a per-register pending scoreboard for outstanding B destinations.
- Flags read-after-write hazards to the decode stage so it can stall.
- Sits between the writeback mux and the register file write inputs (write_reg_addr, write_data, reg_write_en).

---
 rtl/rv_regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rv_regfile_pkg.sv
// Shared constants for the register-file writeback arbiter and its scoreboard.
package rv_regfile_pkg;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Arbiter priority state encoding
  localparam logic [0:0] A_PRIO = 1'b0;
  localparam logic [0:0] B_PRIO = 1'b1;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard for multi-cycle writebacks plus decode hazard lookups.
module regfile_scoreboard
  import rv_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic                  out_en,
  input  logic [REG_ADDR_W-1:0] out_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [NREG-1:0]       pending,
  output logic                  rs1_hazard,
  output logic                  rs2_hazard
);
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Clear first so a same-cycle set of the same register wins
  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_addr] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    if (set_en && (set_addr != REG_ZERO)) begin
      pending_d[set_addr] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= {NREG{1'b0}};
    end else begin
      pending_q <= pending_d;
    end
  end

  // The output-stage write only lands in the register file at the end of its cycle
  always_comb begin
    rs1_hazard = (rs1_addr != REG_ZERO) &&
                 (pending_q[rs1_addr] || (out_en && (out_addr == rs1_addr)));
    rs2_hazard = (rs2_addr != REG_ZERO) &&
                 (pending_q[rs2_addr] || (out_en && (out_addr == rs2_addr)));
  end

  assign pending = pending_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between a single-cycle (A) and a multi-cycle (B) writeback path.
module regfile_wb_arbiter
  import rv_regfile_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [XLEN-1:0]       a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [XLEN-1:0]       b_data,
  output logic                  b_ready,
  input  logic                  b_issue_valid,
  input  logic [REG_ADDR_W-1:0] b_issue_addr,
  output logic                  b_issue_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_hazard,
  output logic                  rs2_hazard,
  output logic [REG_ADDR_W-1:0] write_reg_addr,
  output logic [XLEN-1:0]       write_data,
  output logic                  reg_write_en
);
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [0:0]            state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic                  wen_q, wen_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [NREG-1:0]       pending;
  logic                  a_free_s;
  logic                  issue_acc_s;

  // A is held back while B still owes a write to the same register (WAW)
  always_comb begin
    a_free_s = !pending[a_addr];
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    case (state_q)
      A_PRIO: begin
        a_ready = a_valid && a_free_s;
        b_ready = b_valid && !a_ready;
      end
      B_PRIO: begin
        b_ready = b_valid;
        a_ready = a_valid && !b_valid && a_free_s;
      end
      default: begin
        a_ready = 1'b0;
        b_ready = 1'b0;
      end
    endcase
  end

  always_comb begin
    if (b_ready) begin
      wait_d = 4'd0;
    end else if (b_valid && (wait_q != 4'd15)) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end
    case (state_q)
      A_PRIO:  state_d = (wait_d == MAX_WAIT_C) ? B_PRIO : A_PRIO;
      B_PRIO:  state_d = b_ready ? A_PRIO : B_PRIO;
      default: state_d = A_PRIO;
    endcase
  end

  // x0 writes are consumed but never enabled on the port
  always_comb begin
    if (a_ready) begin
      wen_d   = (a_addr != REG_ZERO);
      waddr_d = a_addr;
      wdata_d = a_data;
    end else if (b_ready) begin
      wen_d   = (b_addr != REG_ZERO);
      waddr_d = b_addr;
      wdata_d = b_data;
    end else begin
      wen_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= A_PRIO;
      wait_q  <= 4'd0;
      wen_q   <= 1'b0;
      waddr_q <= REG_ZERO;
      wdata_q <= {XLEN{1'b0}};
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign b_issue_ready  = (b_issue_addr == REG_ZERO) || !pending[b_issue_addr];
  assign issue_acc_s    = b_issue_valid && b_issue_ready;
  assign reg_write_en   = wen_q;
  assign write_reg_addr = waddr_q;
  assign write_data     = wdata_q;

  regfile_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_en     (issue_acc_s),
    .set_addr   (b_issue_addr),
    .clr_en     (b_ready),
    .clr_addr   (b_addr),
    .out_en     (wen_q),
    .out_addr   (waddr_q),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .pending    (pending),
    .rs1_hazard (rs1_hazard),
    .rs2_hazard (rs2_hazard)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter with a queue-based write-port scoreboard.
module tb_regfile_wb_arbiter;
  localparam int MAX_WAIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, b_issue_valid;
  logic [4:0]  a_addr, b_addr, b_issue_addr, rs1_addr, rs2_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, b_issue_ready, rs1_hazard, rs2_hazard;
  logic [4:0]  write_reg_addr;
  logic [31:0] write_data;
  logic        reg_write_en;

  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .b_issue_valid(b_issue_valid), .b_issue_addr(b_issue_addr), .b_issue_ready(b_issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard),
    .write_reg_addr(write_reg_addr), .write_data(write_data), .reg_write_en(reg_write_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: set of outstanding B destinations, B-starvation bookkeeping, last port write
  bit [31:0] m_pend;
  bit        m_forced;
  int        m_lose;
  bit        m_cur_en;
  bit [4:0]  m_cur_addr;
  bit        got_a, got_b, got_i, got_h1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_haz(input bit [4:0] r);
    return (r != 5'd0) && (m_pend[r] || (m_cur_en && m_cur_addr == r));
  endfunction

  task automatic cycle(input bit rst, input bit av, input bit [4:0] aa, input bit [31:0] ad,
                       input bit bv, input bit [4:0] ba, input bit [31:0] bd,
                       input bit iv, input bit [4:0] ia, input bit [4:0] r1, input bit [4:0] r2);
    int   win;
    bit   iss_ok;
    exp_t e;
    @(negedge clk);
    reset = rst; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    b_issue_valid = iv; b_issue_addr = ia; rs1_addr = r1; rs2_addr = r2;
    #1;
    if (m_forced && bv)           win = 2;
    else if (av && !m_pend[aa])   win = 1;
    else if (bv)                  win = 2;
    else                          win = 0;
    iss_ok = (ia == 5'd0) || !m_pend[ia];
    chk("a_ready", a_ready, 32'(win == 1));
    chk("b_ready", b_ready, 32'(win == 2));
    chk("b_issue_ready", b_issue_ready, 32'(iss_ok));
    chk("rs1_hazard", rs1_hazard, 32'(exp_haz(r1)));
    chk("rs2_hazard", rs2_hazard, 32'(exp_haz(r2)));
    got_a = a_ready; got_b = b_ready; got_i = b_issue_ready; got_h1 = rs1_hazard;
    e.en = 1'b0; e.addr = 5'd0; e.data = 32'd0;
    if (!rst && win == 1) begin e.en = (aa != 5'd0); e.addr = aa; e.data = ad; end
    if (!rst && win == 2) begin e.en = (ba != 5'd0); e.addr = ba; e.data = bd; end
    exp_q.push_back(e);
    if (rst) begin
      m_pend = 32'd0; m_forced = 1'b0; m_lose = 0; m_cur_en = 1'b0; m_cur_addr = 5'd0;
    end else begin
      if (win == 2) m_pend[ba] = 1'b0;
      if (iv && iss_ok && ia != 5'd0) m_pend[ia] = 1'b1;
      if (win == 2) begin
        m_lose = 0; m_forced = 1'b0;
      end else begin
        if (bv && m_lose < 15) m_lose++;
        if (!m_forced && m_lose == MAX_WAIT) m_forced = 1'b1;
      end
      m_cur_en = e.en; m_cur_addr = e.addr;
    end
  endtask

  // Monitor: one expected write-port state per cycle once stimulus starts
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("reg_write_en", reg_write_en, 32'(e.en));
        if (e.en) begin
          chk("write_reg_addr", write_reg_addr, 32'(e.addr));
          chk("write_data", write_data, e.data);
        end
      end
    end
  end

  initial begin
    bit [4:0] bsel;
    bit [4:0] bseq;
    int       start;
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; b_issue_valid = 1'b0;
    a_addr = 5'd0; b_addr = 5'd0; b_issue_addr = 5'd0; a_data = 32'd0; b_data = 32'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    m_pend = 32'd0; m_forced = 1'b0; m_lose = 0; m_cur_en = 1'b0; m_cur_addr = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen", reg_write_en, 32'd0);
    chk("rst_waddr", write_reg_addr, 32'd0);
    chk("rst_wdata", write_data, 32'd0);

    // A writes x5, then idle
    cycle(0, 1, 5'd5, 32'h1234, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
    chk("x5_a_ready", got_a, 32'd1);
    cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd5, 5'd0);
    cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd5, 5'd0);

    // Continuous contention: B forced through on the fourth cycle
    bseq = 5'd0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 5'd1, 32'(i), 1, 5'd2, 32'hB000 + 32'(i), 0, 5'd0, 5'd0, 5'd0);
      bseq = {bseq[3:0], got_b};
    end
    chk("contend_b_pattern", 32'(bseq), 32'b00010);

    // Scoreboard and hazard on x7
    cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7, 5'd7, 5'd0);
    cycle(0, 1, 5'd7, 32'hAAAA, 0, 5'd0, 32'd0, 1, 5'd7, 5'd7, 5'd0);
    chk("x7_a_stall", got_a, 32'd0);
    chk("x7_issue_stall", got_i, 32'd0);
    chk("x7_haz_pending", got_h1, 32'd1);
    cycle(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h7777, 0, 5'd0, 5'd7, 5'd0);
    chk("x7_b_accept", got_b, 32'd1);
    cycle(0, 1, 5'd7, 32'h5555, 0, 5'd0, 32'd0, 0, 5'd7, 5'd7, 5'd0);
    chk("x7_haz_outstage", got_h1, 32'd1);
    chk("x7_a_free", got_a, 32'd1);
    chk("x7_issue_free", got_i, 32'd1);
    cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd6, 5'd0);
    cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd7, 5'd0);
    chk("x7_haz_clear", got_h1, 32'd0);

    // x0 write is consumed silently
    cycle(0, 1, 5'd0, 32'hFFFF, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
    chk("x0_a_ready", got_a, 32'd1);
    cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);

    // Reset with x3 pending and a write in the output stage
    cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd3, 5'd0, 5'd0);
    cycle(0, 1, 5'd9, 32'h9999, 0, 5'd0, 32'd0, 0, 5'd0, 5'd3, 5'd9);
    cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd3, 5'd9);
    cycle(0, 1, 5'd4, 32'h4444, 1, 5'd8, 32'h8888, 0, 5'd0, 5'd3, 5'd9);
    chk("post_rst_haz", got_h1, 32'd0);
    chk("post_rst_a_prio", got_a, 32'd1);

    // Randomized traffic over a narrow register window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      bsel = 5'($urandom_range(0, 7));
      if (m_pend != 32'd0 && ($urandom % 4) != 0) begin
        start = $urandom_range(0, 31);
        for (int k = 0; k < 32; k++) begin
          if (m_pend[(start + k) % 32]) bsel = 5'((start + k) % 32);
        end
      end
      cycle(($urandom % 64) == 0, ($urandom % 3) != 0, 5'($urandom_range(0, 7)), $urandom,
            ($urandom % 2) == 0, bsel, $urandom,
            ($urandom % 3) == 0, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
